// File: rtl/nibble_serial_adder_pkg.sv
// Shared ALU constants for the nibble-serial adder: slice width, FSM encoding
// and a helper for sizing the nibble counter.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A single-nibble counter would be zero bits wide, so keep at least one bit.
    function automatic int cntWidth(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_fac4bit.sv
// 4-bit combinational ripple-carry adder slice built from 1-bit full-adder cells;
// the addition twin of the ALU's 4-bit subtractor slice.
module FAC1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module FAC4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_cell
        FAC1bit u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .sum  (sum[i]),
            .cout (w_carry[i+1])
        );
    end

    assign cout = w_carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit slice processes a nibble per
// clock, LSB first, behind a start/done handshake.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = cntWidth(NIBBLES);

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [NIBBLE_W-1:0] w_nibA;
    logic [NIBBLE_W-1:0] w_nibB;
    logic [NIBBLE_W-1:0] w_nibSum;
    logic                w_nibCout;
    logic                w_last;
    logic [WIDTH-1:0]    w_sumFinal;

    assign w_nibA = r_a[r_cnt*NIBBLE_W +: NIBBLE_W];
    assign w_nibB = r_b[r_cnt*NIBBLE_W +: NIBBLE_W];
    assign w_last = (r_cnt == CNT_W'(NIBBLES - 1));

    FAC4bit u_slice (
        .a    (w_nibA),
        .b    (w_nibB),
        .cin  (r_carry),
        .sum  (w_nibSum),
        .cout (w_nibCout)
    );

    // The last slice result lands in the top nibble, so the finished sum is
    // known at the same edge and zero is valid for the whole DONE cycle.
    assign w_sumFinal = {w_nibSum, r_sum[WIDTH-NIBBLE_W-1:0]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_cnt*NIBBLE_W +: NIBBLE_W] <= w_nibSum;
                    r_carry <= w_nibCout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout <= w_nibCout;
                        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                  (w_nibSum[NIBBLE_W-1] != r_a[WIDTH-1]);
                        r_zero <= (w_sumFinal == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN) || (r_state == DONE);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=32, using a
// plain-arithmetic reference model, a directed vector table and corner sequences.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;

    logic        start16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16, zero16;
    logic [15:0] sum16;

    logic        start32, cin32;
    logic [31:0] a32, b32;
    logic        busy32, done32, cout32, ovf32, zero32;
    logic [31:0] sum32;

    int errors = 0;
    int checks = 0;
    int tbCycle = 0;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) tbCycle <= tbCycle + 1;

    // Result packing used everywhere: {sum (32 bits, zero-extended), cout, ovf, zero}.
    function automatic logic [34:0] refModel(input int w, input logic [31:0] av,
                                             input logic [31:0] bv, input logic cv);
        logic [31:0] mask;
        logic [32:0] full;
        logic [31:0] s;
        logic        co, ov, z;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        full = {1'b0, av & mask} + {1'b0, bv & mask} + {32'h0, cv};
        s    = full[31:0] & mask;
        co   = full[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
        z    = (s == 32'h0);
        return {s, co, ov, z};
    endfunction

    function automatic logic [34:0] pack16();
        return {16'h0, sum16, cout16, ovf16, zero16};
    endfunction

    function automatic logic [34:0] pack32();
        return {sum32, cout32, ovf32, zero32};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Issues one start pulse on the chosen DUT and waits (bounded) for done;
    // returns at the negedge of the done cycle.
    task automatic applyStimulus(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, output logic [34:0] res,
                                 output int lat, output bit busyOk);
        @(negedge clk);
        if (w == 16) begin
            a16 = av[15:0]; b16 = bv[15:0]; cin16 = cv; start16 = 1'b1;
        end else begin
            a32 = av; b32 = bv; cin32 = cv; start32 = 1'b1;
        end
        @(negedge clk);
        start16 = 1'b0;
        start32 = 1'b0;
        lat     = 1;
        busyOk  = 1'b1;
        while (!((w == 16) ? done16 : done32) && lat < 40) begin
            if (!((w == 16) ? busy16 : busy32)) busyOk = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!((w == 16) ? busy16 : busy32)) busyOk = 1'b0;
        res = (w == 16) ? pack16() : pack32();
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [34:0] res;
        logic [34:0] exp;
        int          lat;
        bit          busyOk;
        int          doneCount;
        int          doneAt;
        int          cnt;
        int          prevDone;
        logic [15:0] heldA[3];
        logic [15:0] heldB[3];
        logic        heldC[3];
        logic [31:0] ra, rb;
        logic        rc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;

        @(negedge clk);
        checkOutput("reset16", {44'h0, busy16, done16, sum16, cout16, ovf16, zero16}, 64'h0);
        checkOutput("reset32", {28'h0, busy32, done32, sum32, cout32, ovf32, zero32}, 64'h0);
        rst = 1'b0;

        // Directed table: result, latency, busy throughout, single-cycle done.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].c, res, lat, busyOk);
            exp = {16'h0, vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z};
            checkOutput($sformatf("vec%0d_result", i), {29'h0, res}, {29'h0, exp});
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
            checkOutput($sformatf("vec%0d_busy", i), {63'h0, busyOk}, 64'h1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_donePulse", i), {62'h0, done16, busy16}, 64'h0);
        end

        // start re-asserted during RUN with new, toggling operands must be ignored.
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        doneCount = 0;
        doneAt    = 0;
        res       = '0;
        for (int i = 1; i <= 13; i++) begin
            if (done16) begin
                doneCount++;
                doneAt = i;
                res    = pack16();
            end
            if (i < 5) begin
                a16 = ~a16; b16 = 16'(i * 16'h0F0F); cin16 = ~cin16;
            end else begin
                start16 = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("ignore_doneCount", 64'(doneCount), 64'd1);
        checkOutput("ignore_doneCycle", 64'(doneAt), 64'd5);
        checkOutput("ignore_result", {29'h0, res}, {29'h0, refModel(16, 32'h1111, 32'h2222, 1'b0)});

        // Asynchronous reset in the middle of RUN.
        a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrun_partialSum", {52'h0, sum16[11:0]}, 64'h555);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrun_asyncReset", {44'h0, busy16, done16, sum16, cout16, ovf16, zero16}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(16, 32'h0F0F, 32'h00F1, 1'b0, res, lat, busyOk);
        checkOutput("afterReset_result", {29'h0, res}, {29'h0, refModel(16, 32'h0F0F, 32'h00F1, 1'b0)});
        checkOutput("afterReset_sum", {48'h0, res[18:3]}, 64'h1000);
        checkOutput("afterReset_latency", 64'(lat), 64'd5);

        // start held high: back-to-back operations spaced NIBBLES+2 cycles apart.
        heldA[0] = 16'hABCD; heldB[0] = 16'h1111; heldC[0] = 1'b1;
        heldA[1] = 16'h7000; heldB[1] = 16'h1000; heldC[1] = 1'b0;
        heldA[2] = 16'hF00F; heldB[2] = 16'h0FF1; heldC[2] = 1'b0;
        @(negedge clk);
        a16 = heldA[0]; b16 = heldB[0]; cin16 = heldC[0]; start16 = 1'b1;
        prevDone = 0;
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!done16 && cnt < 20);
            checkOutput($sformatf("held%0d_done", k), {63'h0, done16}, 64'h1);
            checkOutput($sformatf("held%0d_result", k), {29'h0, pack16()},
                        {29'h0, refModel(16, {16'h0, heldA[k]}, {16'h0, heldB[k]}, heldC[k])});
            if (k > 0) checkOutput($sformatf("held%0d_spacing", k), 64'(tbCycle - prevDone), 64'd6);
            prevDone = tbCycle;
            if (k < 2) begin
                a16 = heldA[k+1]; b16 = heldB[k+1]; cin16 = heldC[k+1];
            end else begin
                start16 = 1'b0;
            end
        end

        // Randomized operands against the reference model, both widths.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(1, 0));
            if (i % 50 == 0) begin
                ra = 32'hFFFF_FFFF; rb = 32'h0; rc = 1'b1;
            end
            if (i < 600) begin
                ra[31:16] = 16'h0; rb[31:16] = 16'h0;
                applyStimulus(16, ra, rb, rc, res, lat, busyOk);
                checkOutput($sformatf("rand16_%0d", i), {29'h0, res}, {29'h0, refModel(16, ra, rb, rc)});
                checkOutput($sformatf("rand16_%0d_latency", i), 64'(lat), 64'd5);
            end else begin
                applyStimulus(32, ra, rb, rc, res, lat, busyOk);
                checkOutput($sformatf("rand32_%0d", i), {29'h0, res}, {29'h0, refModel(32, ra, rb, rc)});
                checkOutput($sformatf("rand32_%0d_latency", i), 64'(lat), 64'd9);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder; the addition counterpart to the ALU's ripple-borrow subtractor slices.
- Reuses one 4-bit full-adder slice and processes one nibble per clock, LSB nibble first.
- Sits in the ALU beside the subtractor. The ALU control FSM drives it with a start/done handshake.
- Trades latency for area: one adder slice instead of WIDTH/4 slices.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived; number of RUN cycles; not overridden by users.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result; held until the next accepted start
- cout  output  1  carry out of the MSB
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, nibble counter=0, carry register=0.
  - Operand registers, sum, cout, ovf and zero all cleared to 0. zero resets to 0, not 1.
  - busy=0, done=0.
- IDLE:
  - start=1 captures a, b and cin. Carry register ← cin, counter ← 0, next state RUN.
  - start=0 keeps the state at IDLE. Outputs hold their previous result.
- RUN (exactly NIBBLES cycles):
  - Each cycle the slice adds nibble[k] of A, nibble[k] of B and the carry register.
  - The 4-bit result is written to sum[4k+3:4k], and the carry register takes the slice carry-out.
  - On the last nibble (k=NIBBLES-1):
    - cout ← slice carry-out.
    - ovf ← (a[MSB]==b[MSB]) && (result MSB != a[MSB]), using the captured operands.
    - Next state is DONE.
  - Higher sum nibbles hold stale values until written. Consumers read sum only at done.
- DONE (1 cycle):
  - done=1. zero computed from the complete sum register. Next state IDLE.
- Latency: start sampled at edge 0 → done high in cycle NIBBLES+1 → ready for a new start the cycle after done. Throughput is one operation per NIBBLES+2 cycles.
- start while busy: ignored, no queuing. Inputs a, b and cin may change freely after capture without affecting the result.
- start held high continuously: a new operation is accepted on the IDLE cycle following each done. a, b and cin are re-sampled at that point.
- Arithmetic: unsigned modulo 2^WIDTH.
  - cout = bit WIDTH of a+b+cin.
  - ovf is the signed interpretation.
  - cin only enters nibble 0.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Shared ALU package constants:
  - Nibble width 4.
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 illegal and recovers to IDLE.
  - Counter width $clog2(NIBBLES).
- Sub-module FAC4bit: combinational 4-bit ripple full adder built from FAC1bit cells.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Mirrors the 4-bit subtractor slice and is instantiated once here.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h4321, cin=0 → done in cycle 5 after start; sum=16'h5555, cout=0, ovf=0, zero=0; busy high cycles 1–5.
- a=16'hFFFF, b=16'h0000, cin=1 → carry ripples across all 4 nibbles; sum=16'h0000, cout=1, zero=1, ovf=0.
- a=16'h7FFF, b=16'h0001, cin=0 → sum=16'h8000, ovf=1, cout=0; then a=16'h8000, b=16'h8000 → sum=16'h0000, ovf=1, cout=1, zero=1.
- start re-asserted during RUN with different operands, and a/b toggled after capture → result equals the first operands; second start ignored; no done pulse beyond the one expected.
- rst asserted mid-RUN (after nibble 2) → asynchronously busy=0, done=0, sum=0, cout=0; next start with a=16'h0F0F, b=16'h00F1 → sum=16'h1000.
- start held high for 3 operations, plus a 1000-vector random check against a+b+cin (include WIDTH=32) → done spacing exactly NIBBLES+2 cycles; all results, cout and ovf match the reference model.
